fp_alu_arbiter: RTL and testbench
=================================

FP_ALU_ARBITER -- requirements
Module: fp_alu_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one fp_alu.
REQ-002 SHALL have parameter W, default 32, operand/result width; fixed-point Q(W/2).(W/2), two's complement.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  N_REQ  per-requester operation request.
REQ-006 SHALL have port req_ready  output  N_REQ  one-hot grant; request accepted when req_valid[i] & req_ready[i].
REQ-007 SHALL have port req_a  input  N_REQ*W  operand A, requester i at bits [i*W +: W].
REQ-008 SHALL have port req_b  input  N_REQ*W  operand B, same packing.
REQ-009 SHALL have port req_op  input  N_REQ*2  opcode, 00 ADD, 01 SUB, 10 MUL, 11 DIV, requester i at [i*2 +: 2].
REQ-010 SHALL have port rsp_valid  output  N_REQ  one-hot; result valid for requester i.
REQ-011 SHALL have port rsp_ready  input  N_REQ  requester i accepts result.
REQ-012 SHALL have port rsp_result  output  W  registered result, shared by all requesters.
REQ-013 SHALL have port op_count  output  16  completed-operation counter.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL instantiate exactly one fp_alu (n=W), fed only from internal operand/op registers.
REQ-016 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-017 IDLE: if any req_valid, SHALL assert req_ready for one cycle to the round-robin winner and capture its a, b, op, and index; next state EXEC; else stay IDLE with req_ready all zero.
REQ-018 Round-robin: search starts at index last_grant+1 modulo N_REQ; last_grant updates on every grant; last_grant reset value N_REQ-1 (requester 0 wins first).
REQ-019 req_ready SHALL be zero in EXEC and RESP; req_valid during those states is ignored, not lost (requester holds it).
REQ-020 EXEC: SHALL register fp_alu output into rsp_result; next state RESP; lasts exactly one cycle.
REQ-021 RESP: rsp_valid[granted index] SHALL be high, all other bits low, rsp_result stable until rsp_ready[granted index] is high at a clock edge; then next state IDLE and op_count increments.
REQ-022 rsp_ready bits of non-granted requesters SHALL be ignored.
REQ-023 Minimum latency grant-to-rsp_valid: 2 cycles; minimum issue interval 3 cycles.
REQ-024 op_count SHALL wrap 0xFFFF -> 0x0000 without flag.
REQ-025 Requester withdrawing req_valid before grant SHALL not be granted.

Reset
REQ-026 On rst (asynchronous, any state, including mid-EXEC/RESP) SHALL go to IDLE; pending operation discarded.
REQ-027 Reset values: req_ready 0, rsp_valid 0, rsp_result 0, op_count 0, busy 0, last_grant N_REQ-1, captured operands 0.

Configuration
REQ-028 Macro FP_ARB_DIVZERO_EN SHALL control divide-by-zero handling.
REQ-029 With FP_ARB_DIVZERO_EN: DIV with captured b==0 SHALL bypass fp_alu result; rsp_result = 0x7FFF_FFFF (W=32; max positive) if a>=0, 0x8000_0001 if a<0; output port div_zero (1 bit) high with rsp_valid for that response, else 0; reset 0.
REQ-030 Without FP_ARB_DIVZERO_EN: no div_zero port; DIV by zero result unspecified; all other behaviour identical.

Verification
REQ-031 Single op: req 0 MUL a=0x0003_0000 b=0x0002_0000 -> req_ready[0] one cycle, rsp_valid[0] 2 cycles later, rsp_result=0x0006_0000, op_count=1.
REQ-032 Contention: all four req_valid high, rsp_ready tied high, ADD 1.0+1.0 -> grants in order 0,1,2,3, each 0x0002_0000, grants 3 cycles apart.
REQ-033 Backpressure: req 2 SUB a=0x0001_0000 b=0x0003_0000, rsp_ready low 5 cycles -> rsp_valid[2] and rsp_result=0xFFFE_0000 held 5 cycles, no new grant, busy high.
REQ-034 Reset mid-op: rst asserted in EXEC -> same cycle rsp_valid=0, busy=0; after release, requester 0 wins first.
REQ-035 Divide by zero (macro on): DIV a=0xFFFF_0000 b=0 -> rsp_result=0x8000_0001, div_zero=1; DIV 0x0004_0000/0x0002_0000 -> 0x0002_0000, div_zero=0.
REQ-036 Wrap: preload via 65536 completed ops -> op_count returns to 0x0000.

Source files
------------

// File: rtl/fp_alu_arbiter.sv
// fp_alu_arbiter: round-robin sharing of one Q(W/2).(W/2) fixed-point ALU.
// Optional FP_ARB_DIVZERO_EN: saturated divide-by-zero result plus div_zero flag.

module fp_alu #(
  parameter int n = 32
) (
  input  logic [n-1:0] a_i,
  input  logic [n-1:0] b_i,
  input  logic [1:0]   op_i,
  output logic [n-1:0] y_o
);
  localparam int F = n / 2;

  logic signed [2*n-1:0] ax, bx, prod, dvd, quot;
  logic unused_bits;

  always_comb begin
    ax   = {{n{a_i[n-1]}}, a_i};
    bx   = {{n{b_i[n-1]}}, b_i};
    prod = ax * bx;
    dvd  = ax <<< F;
    // keep the divider X-free on a zero divisor
    quot = (b_i == '0) ? '0 : dvd / bx;
    unique case (op_i)
      2'b00:   y_o = a_i + b_i;
      2'b01:   y_o = a_i - b_i;
      2'b10:   y_o = prod[F +: n];
      default: y_o = quot[n-1:0];
    endcase
  end

  assign unused_bits = ^{prod[2*n-1:n+F], prod[F-1:0], quot[2*n-1:n]};
endmodule

module fp_alu_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  input  logic [N_REQ*2-1:0] req_op,
  output logic [N_REQ-1:0]   rsp_valid,
  input  logic [N_REQ-1:0]   rsp_ready,
  output logic [W-1:0]       rsp_result,
  output logic [15:0]        op_count,
  output logic               busy
`ifdef FP_ARB_DIVZERO_EN
  ,
  output logic               div_zero
`endif
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] win, cand;
  logic          found;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  res_q, res_d;
  logic [W-1:0]  alu_y;
  logic [1:0]    op_q, op_d;
  logic [15:0]   cnt_q, cnt_d;

`ifdef FP_ARB_DIVZERO_EN
  localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINP = {1'b1, {(W-2){1'b0}}, 1'b1};
  logic dz_q, dz_d;
`endif

  fp_alu #(.n(W)) u_alu (
    .a_i  (a_q),
    .b_i  (b_q),
    .op_i (op_q),
    .y_o  (alu_y)
  );

  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(last_q) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    rsp_valid = '0;
`ifdef FP_ARB_DIVZERO_EN
    dz_d      = dz_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          req_ready[win] = 1'b1;
          last_d  = win;
          idx_d   = win;
          a_d     = req_a[int'(win)*W +: W];
          b_d     = req_b[int'(win)*W +: W];
          op_d    = req_op[int'(win)*2 +: 2];
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d = alu_y;
`ifdef FP_ARB_DIVZERO_EN
        dz_d = 1'b0;
        if (op_q == 2'b11 && b_q == '0) begin
          dz_d  = 1'b1;
          res_d = a_q[W-1] ? MINP : MAXP;
        end
`endif
        state_d = RESP;
      end
      RESP: begin
        rsp_valid[idx_q] = 1'b1;
        if (rsp_ready[idx_q]) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // no grant may leak out while reset holds the FSM
    if (rst) req_ready = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IW'(N_REQ - 1);
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
`ifdef FP_ARB_DIVZERO_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
`ifdef FP_ARB_DIVZERO_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign rsp_result = res_q;
  assign op_count   = cnt_q;
  assign busy       = (state_q != IDLE);
`ifdef FP_ARB_DIVZERO_EN
  assign div_zero   = dz_q & (state_q == RESP);
`endif
endmodule

// File: tb/tb_fp_alu_arbiter.sv
// Bench for fp_alu_arbiter: scoreboard of expected responses per grant.
// Divide-by-zero checks compile in with FP_ARB_DIVZERO_EN.

module tb_fp_alu_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [7:0]   req_op;
  logic [3:0]   rsp_valid;
  logic [3:0]   rsp_ready;
  logic [31:0]  rsp_result;
  logic [15:0]  op_count;
  logic         busy;
`ifdef FP_ARB_DIVZERO_EN
  logic         div_zero;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          idx;
    logic [31:0] res;
    logic        dz;
  } exp_t;
  exp_t scb[$];

  fp_alu_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .op_count   (op_count),
    .busy       (busy)
`ifdef FP_ARB_DIVZERO_EN
    ,
    .div_zero   (div_zero)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sbv, r;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    case (op)
      2'b00: r = sa + sbv;
      2'b01: r = sa - sbv;
      2'b10: r = (sa * sbv) >>> 16;
      default: begin
        if (b == 32'd0) r = a[31] ? 64'h8000_0001 : 64'h7FFF_FFFF;
        else r = (sa * 65536) / sbv;
      end
    endcase
    return r[31:0];
  endfunction

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_op[i*2 +: 2]  = op;
  endtask

  task automatic push_exp(input int i);
    exp_t e;
    e.idx = i;
    e.res = model(req_op[i*2 +: 2], req_a[i*32 +: 32], req_b[i*32 +: 32]);
    e.dz  = (req_op[i*2 +: 2] == 2'b11) && (req_b[i*32 +: 32] == 32'd0);
    scb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    scb.delete();
    @(negedge clk);
  endtask

  task automatic run_one(input int i, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bit ok = 0;
    set_req(i, op, a, b);
    rsp_ready = 4'hF;
    req_valid = 4'b1 << i;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (req_ready[i]) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL run_one_grant idx=%0d got req_ready=%b want bit set", i, req_ready);
      req_valid = '0;
      return;
    end
    push_exp(i);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    e = scb.pop_front();
    checks++;
    if (rsp_valid !== (4'b1 << e.idx) || rsp_result !== e.res) begin
      errors++;
      $display("FAIL run_one_rsp got valid=%b result=%h want valid=%b result=%h",
               rsp_valid, rsp_result, 4'b1 << e.idx, e.res);
    end
`ifdef FP_ARB_DIVZERO_EN
    checks++;
    if (div_zero !== e.dz) begin
      errors++;
      $display("FAIL div_zero_flag got %b want %b", div_zero, e.dz);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'hF;
    rsp_ready = 4'hF;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 4'b0) begin
      errors++; $display("FAIL reset_req_ready got %b want 0000", req_ready);
    end
    checks++;
    if (rsp_valid !== 4'b0) begin
      errors++; $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid);
    end
    checks++;
    if (rsp_result !== 32'd0) begin
      errors++; $display("FAIL reset_rsp_result got %h want 0", rsp_result);
    end
    checks++;
    if (op_count !== 16'd0) begin
      errors++; $display("FAIL reset_op_count got %h want 0", op_count);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b want 0", busy);
    end
    req_valid = '0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    exp_t e;
    set_req(0, 2'b10, 32'h0003_0000, 32'h0002_0000);
    rsp_ready = 4'hF;
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL single_grant got %b want 0001", req_ready);
    end
    push_exp(0);
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if (req_ready !== 4'b0 || busy !== 1'b1 || rsp_valid !== 4'b0) begin
      errors++;
      $display("FAIL single_exec got ready=%b busy=%b valid=%b want 0000 1 0000",
               req_ready, busy, rsp_valid);
    end
    @(negedge clk);
    #1;
    e = scb.pop_front();
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_result !== e.res || e.res !== 32'h0006_0000) begin
      errors++;
      $display("FAIL single_rsp got valid=%b result=%h want 0001 00060000",
               rsp_valid, rsp_result);
    end
    @(negedge clk);
    #1;
    checks++;
    if (op_count !== 16'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_count got count=%h busy=%b want 0001 0", op_count, busy);
    end
  endtask

  task automatic test_contention();
    exp_t e;
    int ng = 0;
    int nr = 0;
    int last_cyc = -1;
    int gi;
    logic [3:0] clr = '0;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 2'b00, 32'h0001_0000, 32'h0001_0000);
    rsp_ready = 4'hF;
    req_valid = 4'hF;
    for (int cyc = 0; cyc < 40 && nr < 4; cyc++) begin
      req_valid = req_valid & ~clr;
      clr = '0;
      #1;
      if (|(req_ready & req_valid)) begin
        checks++;
        if (req_ready !== (4'b1 << ng)) begin
          errors++;
          $display("FAIL contention_order got %b want %b", req_ready, 4'b1 << ng);
        end
        if (ng > 0) begin
          checks++;
          if (cyc - last_cyc != 3) begin
            errors++;
            $display("FAIL contention_gap got %0d want 3", cyc - last_cyc);
          end
        end
        gi = oh_idx(req_ready);
        if (gi >= 0) push_exp(gi);
        last_cyc = cyc;
        clr = req_ready;
        ng++;
      end
      if (|(rsp_valid & rsp_ready)) begin
        checks++;
        if (scb.size() == 0) begin
          errors++;
          $display("FAIL contention_spurious got valid=%b want none", rsp_valid);
        end else begin
          e = scb.pop_front();
          if (rsp_valid !== (4'b1 << e.idx) || rsp_result !== 32'h0002_0000) begin
            errors++;
            $display("FAIL contention_rsp got valid=%b result=%h want %b 00020000",
                     rsp_valid, rsp_result, 4'b1 << e.idx);
          end
        end
        nr++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    checks++;
    if (nr != 4) begin
      errors++; $display("FAIL contention_timeout got %0d responses want 4", nr);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    set_req(2, 2'b01, 32'h0001_0000, 32'h0003_0000);
    set_req(0, 2'b00, 32'h0005_0000, 32'hFFFD_0000);
    rsp_ready = '0;
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL bp_grant got %b want 0100", req_ready);
    end
    push_exp(2);
    @(negedge clk);
    req_valid = 4'b0001;
    @(negedge clk);
    e = scb.pop_front();
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (rsp_valid !== 4'b0100 || rsp_result !== 32'hFFFE_0000) begin
        errors++;
        $display("FAIL bp_hold%0d got valid=%b result=%h want 0100 fffe0000",
                 k, rsp_valid, rsp_result);
      end
      checks++;
      if (req_ready !== 4'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_nogrant%0d got ready=%b busy=%b want 0000 1", k, req_ready, busy);
      end
      @(negedge clk);
    end
    rsp_ready = 4'b1011;
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 4'b0100 || rsp_result !== e.res) begin
      errors++;
      $display("FAIL bp_foreign_ready got valid=%b result=%h want 0100 %h",
               rsp_valid, rsp_result, e.res);
    end
    rsp_ready = 4'b0100;
    @(negedge clk);
    rsp_ready = 4'hF;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL bp_next_grant got %b want 0001", req_ready);
    end
    push_exp(0);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    e = scb.pop_front();
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_result !== 32'h0002_0000 || e.res !== rsp_result) begin
      errors++;
      $display("FAIL bp_second_rsp got valid=%b result=%h want 0001 00020000",
               rsp_valid, rsp_result);
    end
    @(negedge clk);
  endtask

  task automatic test_withdraw();
    set_req(1, 2'b00, 32'h0001_0000, 32'h0002_0000);
    set_req(3, 2'b00, 32'h0003_0000, 32'h0002_0000);
    run_one(0, 2'b00, 32'h0000_8000, 32'h0000_8000);
    set_req(0, 2'b00, 32'h0001_0000, 32'h0001_0000);
    req_valid = 4'b0001;
    #1;
    push_exp(0);
    @(negedge clk);
    req_valid = 4'b1010;
    @(negedge clk);
    scb.delete();
    req_valid = 4'b1000;
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++; $display("FAIL withdraw_grant got %b want 1000", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 4'b1000 || rsp_result !== 32'h0005_0000) begin
      errors++;
      $display("FAIL withdraw_rsp got valid=%b result=%h want 1000 00050000",
               rsp_valid, rsp_result);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 4; i++) set_req(i, 2'b00, 32'h0001_0000, 32'h0001_0000);
    rsp_ready = 4'hF;
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL midop_exec_busy got %b want 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 4'b0 || busy !== 1'b0 || rsp_result !== 32'd0) begin
      errors++;
      $display("FAIL midop_reset got valid=%b busy=%b result=%h want 0000 0 0",
               rsp_valid, busy, rsp_result);
    end
    @(negedge clk);
    rst = 1'b0;
    scb.delete();
    req_valid = 4'hF;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL midop_first_grant got %b want 0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_div();
    run_one(1, 2'b11, 32'h0004_0000, 32'h0002_0000);
    run_one(2, 2'b11, 32'hFFFF_0000, 32'h0002_0000);
`ifdef FP_ARB_DIVZERO_EN
    run_one(3, 2'b11, 32'hFFFF_0000, 32'h0000_0000);
    run_one(0, 2'b11, 32'h0001_0000, 32'h0000_0000);
    run_one(1, 2'b11, 32'h0004_0000, 32'h0002_0000);
`endif
  endtask

  task automatic test_wrap();
    dut.cnt_q = 16'hFFFE;
    run_one(0, 2'b10, 32'hFFFE_0000, 32'h0000_8000);
    #1;
    checks++;
    if (op_count !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_pre got %h want ffff", op_count);
    end
    run_one(1, 2'b01, 32'h0000_0000, 32'h0000_0001);
    #1;
    checks++;
    if (op_count !== 16'h0000) begin
      errors++; $display("FAIL wrap_zero got %h want 0000", op_count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_withdraw();
    test_reset_midop();
    test_div();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
